// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and grant-hold.
// Optional forced rotation after MAX_HOLD cycles when RR_HOLD_LIMIT_EN is defined.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt_onehot,
  output logic       gnt_valid,
  output logic       gnt_new
);

  typedef enum logic {IDLE, GRANT} state_e;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2**CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter4: illegal MAX_HOLD/CNT_W combination");
  end

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [3:0] gnt_q;
  logic       gnt_valid_q;
  logic       gnt_new_q;
`ifdef RR_HOLD_LIMIT_EN
  logic [CNT_W-1:0] hold_cnt_q;
`endif

  // First set bit of r, scanning p, p+1, ... mod 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] oh);
    enc = 2'd0;
    for (int k = 0; k < 4; k++) if (oh[k]) enc = 2'(k);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  logic [1:0] own, nptr, idle_w, hand_w;
  logic [3:0] others;

  always_comb begin
    own    = enc(gnt_q);
    nptr   = own + 2'd1;
    others = req & ~gnt_q;
    idle_w = pick(req, ptr_q);
    hand_w = pick(others, nptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      gnt_new_q   <= 1'b0;
`ifdef RR_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      gnt_new_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q       <= onehot(idle_w);
            gnt_valid_q <= 1'b1;
            gnt_new_q   <= 1'b1;
            state_q     <= GRANT;
`ifdef RR_HOLD_LIMIT_EN
            hold_cnt_q  <= CNT_W'(1);
`endif
          end
        end
        GRANT: begin
          if (!req[own]) begin
            // Release: owner drops to lowest priority, handoff without a bubble.
            ptr_q <= nptr;
            if (|others) begin
              gnt_q     <= onehot(hand_w);
              gnt_new_q <= 1'b1;
`ifdef RR_HOLD_LIMIT_EN
              hold_cnt_q <= CNT_W'(1);
`endif
            end else begin
              gnt_q       <= 4'b0000;
              gnt_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
`ifdef RR_HOLD_LIMIT_EN
          else if (hold_cnt_q == CNT_W'(MAX_HOLD) && |others) begin
            ptr_q      <= nptr;
            gnt_q      <= onehot(hand_w);
            gnt_new_q  <= 1'b1;
            hold_cnt_q <= CNT_W'(1);
          end else if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_onehot = gnt_q;
  assign gnt_valid  = gnt_valid_q;
  assign gnt_new    = gnt_new_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed + randomized bench for rr_arbiter4 against an integer-level round-robin model.
module tb_rr_arbiter4;
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt_onehot;
  logic       gnt_valid, gnt_new;

  int total = 0, passed = 0;

  // Reference model state: owner index or -1 when idle.
  int m_owner = -1, m_ptr = 0, m_hold = 0;
  bit m_new = 0;

  rr_arbiter4 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt_onehot(gnt_onehot), .gnt_valid(gnt_valid), .gnt_new(gnt_new)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic int first_req(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_new = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    logic [3:0] oth;
    m_new = 0;
    if (m_owner < 0) begin
      if (r != 0) begin m_owner = first_req(r, m_ptr); m_new = 1; m_hold = 1; end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = first_req(r, m_ptr);
      if (m_owner >= 0) begin m_new = 1; m_hold = 1; end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
      if (m_hold == MAXH && oth != 0) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = first_req(oth, m_ptr);
        m_new = 1; m_hold = 1;
      end else if (m_hold < MAXH) m_hold++;
`else
      if (m_hold < MAXH) m_hold++;
`endif
    end
  endtask

  // Apply r for one edge, advance the model, then compare outputs and invariants.
  task automatic step(input logic [3:0] r, input string tag);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check({tag, ".gnt"}, gnt_onehot, m_gnt());
    check({tag, ".valid"}, {3'b0, gnt_valid}, {3'b0, m_owner >= 0});
    check({tag, ".new"}, {3'b0, gnt_new}, {3'b0, m_new});
    check({tag, ".inv_onehot"}, {3'b0, $onehot0(gnt_onehot)}, 4'd1);
    check({tag, ".inv_valid"}, {3'b0, gnt_valid}, {3'b0, |gnt_onehot});
    if (gnt_new) check({tag, ".inv_req"}, {3'b0, |(gnt_onehot & r)}, 4'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0000;
    model_reset();
    #1;
    check("rst.gnt", gnt_onehot, 4'b0000);
    check("rst.flags", {2'b0, gnt_valid, gnt_new}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    do_reset();

    // Idle with no requests.
    for (int i = 0; i < 5; i++) step(4'b0000, "idle");

    // First grant, hold, then handoff with no bubble.
    step(4'b1010, "first");
    check("first.exact", gnt_onehot, 4'b0010);
    for (int i = 0; i < 4; i++) step(4'b1010, "hold1");
    step(4'b1000, "handoff");
    check("handoff.exact", gnt_onehot, 4'b1000);

    // Asynchronous reset mid-grant drops outputs immediately.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.gnt", gnt_onehot, 4'b0000);
    check("async_rst.flags", {2'b0, gnt_valid, gnt_new}, 4'b0000);
    model_reset();
    do_reset();

    // Full rotation with wrap.
    step(4'b1111, "rot0"); check("rot0.exact", gnt_onehot, 4'b0001);
    step(4'b1110, "rot1"); check("rot1.exact", gnt_onehot, 4'b0010);
    step(4'b1101, "rot2"); check("rot2.exact", gnt_onehot, 4'b0100);
    step(4'b1011, "rot3"); check("rot3.exact", gnt_onehot, 4'b1000);
    step(4'b0111, "rot4"); check("rot4.exact", gnt_onehot, 4'b0001);

    // Owner 3 releases to idle; pointer wraps to 0.
    step(4'b1000, "to3");  check("to3.exact", gnt_onehot, 4'b1000);
    step(4'b0000, "rel3"); check("rel3.exact", gnt_onehot, 4'b0000);
    step(4'b1001, "wrap"); check("wrap.exact", gnt_onehot, 4'b0001);

    // Constant competition: rotates only with the hold limit.
    for (int i = 0; i < 110; i++) step(4'b0011, "contend");
`ifndef RR_HOLD_LIMIT_EN
    check("contend.noforce", gnt_onehot, 4'b0001);
`endif
    do_reset();
    for (int i = 0; i < 20; i++) step(4'b0001, "solo");
    check("solo.exact", gnt_onehot, 4'b0001);

    // Randomized sticky-request traffic.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      step(r, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
